// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   FWD_*       : operand forwarding select encodings
//   mem_state_t : data-memory wait FSM states
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUOutM

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/forward_sel.sv
// Forwarding select for one Execute-stage source operand.
//   ra_e        : source register in Execute
//   wa3_m/w     : destination registers in Memory / Writeback
//   reg_write_m/w : qualified register writes in Memory / Writeback
//   ig_rn       : operand unused; force register-file select
//   fwd         : 2-bit select (FWD_RF / FWD_WB / FWD_MEM)
module forward_sel
    import hazard_pkg::*;
(
    input  logic [3:0] ra_e,
    input  logic [3:0] wa3_m,
    input  logic [3:0] wa3_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       ig_rn,
    output logic [1:0] fwd
);

    // Memory stage holds the younger result, so it wins over Writeback.
    always_comb begin
        fwd = FWD_RF;
        if (!ig_rn) begin
            if (reg_write_m && (ra_e == wa3_m))
                fwd = FWD_MEM;
            else if (reg_write_w && (ra_e == wa3_w))
                fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and memory-wait controller for the 5-stage pipelined ARM core.
//   Inputs : stage register addresses, RegWrite/MemtoReg/PCSrc per stage,
//            BranchTakenE, IgRnE, data memory request/ready.
//   Outputs: ForwardAE/BE operand selects, Stall{F,D,E,M,W}, Flush{D,E},
//            sticky MemErr timeout flag, saturating StallCycles/FlushCycles.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             IgRnE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCycles
);

    localparam int              WCW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MEM_TIMEOUT);

    logic ldr_stall;
    logic pc_wr_pending;
    logic freeze;

    forward_sel u_fwd_a (
        .ra_e        (RA1E),
        .wa3_m       (WA3M),
        .wa3_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .ig_rn       (IgRnE),
        .fwd         (ForwardAE)
    );

    forward_sel u_fwd_b (
        .ra_e        (RA2E),
        .wa3_m       (WA3M),
        .wa3_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .ig_rn       (1'b0),
        .fwd         (ForwardBE)
    );

    // Freeze dominates: while any stage is held, no flush may be issued,
    // otherwise an instruction sitting in a held register would be lost.
    always_comb begin
        ldr_stall     = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
        pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
        freeze        = MemReqM & ~MemReadyM;

        StallF = ldr_stall | pc_wr_pending | freeze;
        StallD = ldr_stall | freeze;
        StallE = freeze;
        StallM = freeze;
        StallW = freeze;
        FlushD = (pc_wr_pending | PCSrcW | BranchTakenE) & ~freeze;
        FlushE = (ldr_stall | BranchTakenE) & ~freeze;
    end

    mem_state_t     state;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_next;

    // First frozen cycle loads 1; afterwards count up, holding at the limit.
    always_comb begin
        if (state == ST_IDLE)
            wait_next = WCW'(1);
        else if (wait_cnt == WAIT_MAX)
            wait_next = wait_cnt;
        else
            wait_next = wait_cnt + WCW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else if ((state == ST_WAIT) && MemReadyM) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else if (freeze) begin
            state    <= ST_WAIT;
            wait_cnt <= wait_next;
            if (wait_next == WAIT_MAX)
                MemErr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCycles <= '0;
        end else begin
            if ((StallD | freeze) && (StallCycles != '1))
                StallCycles <= StallCycles + CNT_W'(1);
            if ((FlushD | FlushE) && (FlushCycles != '1))
                FlushCycles <= FlushCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_unit;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemReadyM;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, IgRnE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
    logic [CW-1:0] StallCycles, FlushCycles;

    hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .IgRnE(IgRnE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit checking = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    // ---------------- behavioural model ----------------
    bit m_in_wait;
    int m_run;       // frozen cycles in the current memory access
    bit m_err;
    int m_stalls;    // unbounded counts; saturation applied on compare
    int m_flushes;

    function automatic logic [1:0] m_fwd(input logic [3:0] ra, input bit ig);
        if (ig) return 2'd0;
        if (RegWriteM && ra == WA3M) return 2'd2;
        if (RegWriteW && ra == WA3W) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit m_ldr();
        return MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    endfunction

    function automatic bit m_freeze();
        return MemReqM && !MemReadyM;
    endfunction

    function automatic bit m_pcw();
        return PCSrcD || PCSrcE || PCSrcM;
    endfunction

    always @(posedge clk) begin
        if (checking) begin
            if (reset) begin
                m_in_wait = 0; m_run = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
            end else begin
                bit fr, fd, fe;
                fr = m_freeze();
                fd = (m_pcw() || PCSrcW || BranchTakenE) && !fr;
                fe = (m_ldr() || BranchTakenE) && !fr;
                if (m_ldr() || fr) m_stalls++;
                if (fd || fe) m_flushes++;
                if (fr) begin
                    m_run = m_in_wait ? m_run + 1 : 1;
                    m_in_wait = 1;
                    if (m_run >= TO) m_err = 1;
                end else if (m_in_wait && MemReadyM) begin
                    m_in_wait = 0;
                    m_run = 0;
                end
            end
        end
    end

    // Compare process: all outputs every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            bit fr, ld;
            fr = m_freeze();
            ld = m_ldr();
            check("ForwardAE", 32'(ForwardAE), 32'(m_fwd(RA1E, IgRnE)));
            check("ForwardBE", 32'(ForwardBE), 32'(m_fwd(RA2E, 1'b0)));
            check("StallF", 32'(StallF), 32'(ld || m_pcw() || fr));
            check("StallD", 32'(StallD), 32'(ld || fr));
            check("StallEMW", {29'd0, StallE, StallM, StallW}, fr ? 32'd7 : 32'd0);
            check("FlushD", 32'(FlushD), 32'((m_pcw() || PCSrcW || BranchTakenE) && !fr));
            check("FlushE", 32'(FlushE), 32'((ld || BranchTakenE) && !fr));
            check("MemErr", 32'(MemErr), 32'(m_err));
            check("StallCycles", 32'(StallCycles), 32'(m_stalls > SAT ? SAT : m_stalls));
            check("FlushCycles", 32'(FlushCycles), 32'(m_flushes > SAT ? SAT : m_flushes));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        {RA1D, RA2D, RA1E, RA2E} = {4'd1, 4'd2, 4'd3, 4'd4};
        {WA3E, WA3M, WA3W} = {4'd8, 4'd9, 4'd10};
        {RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemReadyM} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, IgRnE} = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        checking = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check("rst_StallCycles", 32'(StallCycles), 32'd0);
        check("rst_FlushCycles", 32'(FlushCycles), 32'd0);
        check("rst_MemErr", 32'(MemErr), 32'd0);

        // Forwarding priority
        next_cycle();
        RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
        #1 check("fwd_mem", 32'(ForwardAE), 32'd2);
        RegWriteM = 0;
        #1 check("fwd_wb", 32'(ForwardAE), 32'd1);
        IgRnE = 1;
        #1 check("fwd_ign", 32'(ForwardAE), 32'd0);

        // Load-use
        next_cycle();
        idle();
        MemtoRegE = 1; WA3E = 5; RA2D = 5;
        #1 check("ldr_stalls", {29'd0, StallF, StallD, FlushE}, 32'd7);
        check("ldr_flushd", 32'(FlushD), 32'd0);
        next_cycle();
        idle();
        #1 check("ldr_cnt", 32'(StallCycles), 32'd1);

        // Branch, then PC write in Decode
        BranchTakenE = 1;
        #1 check("br_flush", {30'd0, FlushD, FlushE}, 32'd3);
        next_cycle();
        idle();
        PCSrcD = 1;
        #1 check("pcd", {29'd0, StallF, FlushD, FlushE}, 32'd6);

        // Memory wait of 3 cycles with a flush request that must be held off
        next_cycle();
        idle();
        reset = 1;
        next_cycle();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1; MemReadyM = 0; BranchTakenE = 1;
            #1 check("wait_hold", {25'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, 32'h7C);
            next_cycle();
        end
        MemReadyM = 1; BranchTakenE = 0;
        next_cycle();
        idle();
        #1 check("wait_cnt", 32'(StallCycles), 32'd3);
        check("wait_noerr", 32'(MemErr), 32'd0);
        check("wait_noflush", 32'(FlushCycles), 32'd0);

        // Timeout
        for (int i = 0; i < 6; i++) begin
            MemReqM = 1; MemReadyM = 0;
            next_cycle();
            if (i == 2) check("to_before", 32'(MemErr), 32'd0);
            if (i == 3) check("to_after", 32'(MemErr), 32'd1);
        end
        MemReadyM = 1;
        next_cycle();
        idle();
        #1 check("to_sticky", 32'(MemErr), 32'd1);
        reset = 1;
        next_cycle();
        reset = 0;
        #1 check("to_rst", {31'd0, MemErr}, 32'd0);
        check("to_rst_cnt", {24'd0, StallCycles, FlushCycles}, 32'd0);
        MemReqM = 1; MemReadyM = 1;
        #1 check("ready_same", 32'(StallE), 32'd0);

        // Counter saturation
        next_cycle();
        idle();
        MemtoRegE = 1; WA3E = 1;
        repeat (20) next_cycle();
        idle();
        #1 check("sat", 32'(StallCycles), 32'hF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            reset = ($urandom_range(0, 99) == 0);
            RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
            RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
            WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
            WA3W = 4'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = ($urandom_range(0, 3) == 0);
            MemReqM   = ($urandom_range(0, 2) != 0);
            MemReadyM = ($urandom_range(0, 99) < 35);
            PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
            PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            IgRnE = ($urandom_range(0, 3) == 0);
        end
        next_cycle();
        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard and memory-wait controller for the 5-stage pipelined ARM core. It consumes the per-stage control signals the controller produces (RegWrite/MemtoReg/PCSrc per stage, BranchTakenE, IgRnE) plus register addresses from the datapath. It returns forwarding selects and the stall/flush signals the controller and datapath pipeline registers consume. It also freezes the whole pipeline while a multi-cycle data memory is busy, detects memory timeouts, and keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, number of consecutive wait cycles after which MemErr is set.
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
RA1D, RA2D  input  4  source registers in Decode.
RA1E, RA2E  input  4  source registers in Execute.
WA3E, WA3M, WA3W  input  4  destination registers in Execute, Memory and Writeback.
RegWriteM, RegWriteW  input  1  condition-qualified register writes.
MemtoRegE  input  1  load in Execute.
MemReqM  input  1  data memory access in Memory (load or store).
MemReadyM  input  1  data memory response for the current access.
PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1  PC write in flight, one per stage.
BranchTakenE  input  1  branch resolved as taken in Execute.
IgRnE  input  1  Rn unused; suppress forwarding on operand A.
ForwardAE, ForwardBE  output  2  operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
StallF, StallD, StallE, StallM, StallW  output  1  pipeline register enables (active-high hold).
FlushD, FlushE  output  1  pipeline register clears (FlushE drives the controller's D/E clear).
MemErr  output  1  sticky memory timeout flag.
StallCycles, FlushCycles  output  CNT_W  saturating performance counters.

Behaviour:
- Forwarding, A operand (combinational):
  - 10 if RegWriteM and RA1E==WA3M;
  - else 01 if RegWriteW and RA1E==WA3W;
  - else 00.
  - Forced to 00 when IgRnE=1.
- Forwarding, B operand: same rule using RA2E, with no IgRn override.
- Priority: M over W when both match.
- LDRstall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- Freeze = MemReqM & ~MemReadyM (combinational, same-cycle).
- Stall and flush outputs:
  - StallF = LDRstall | PCWrPending | Freeze.
  - StallD = LDRstall | Freeze.
  - StallE = StallM = StallW = Freeze.
  - FlushD = (PCWrPending | PCSrcW | BranchTakenE) & ~Freeze.
  - FlushE = (LDRstall | BranchTakenE) & ~Freeze.
- Freeze dominates: no flush is issued while any stage is held, so no instruction is lost.
- Memory FSM states: IDLE, WAIT.
  - IDLE -> WAIT when Freeze=1; WaitCnt loads 1.
  - WAIT: while Freeze=1, WaitCnt increments, saturating at MEM_TIMEOUT.
  - WAIT -> IDLE when MemReadyM=1.
  - MemErr is set on the edge where WaitCnt reaches MEM_TIMEOUT and stays set until reset. Freeze continues regardless of MemErr.
  - MemReadyM=1 on the same cycle as the request: no freeze, FSM stays IDLE.
- StallCycles: +1 on each cycle with StallD | Freeze.
- FlushCycles: +1 on each cycle with FlushD | FlushE.
- Both counters saturate at all-ones and never wrap.
- Reset values: FSM=IDLE, WaitCnt=0, MemErr=0, StallCycles=0, FlushCycles=0.
- Combinational outputs follow their inputs during reset.
- Reset in WAIT returns to IDLE on the next edge, regardless of MemReadyM.
- No forwarding is special-cased for register 15; the datapath handles PC reads.

Decomposition:
- hazard_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding ST_IDLE, ST_WAIT.
- One sub-module, forward_sel, is instantiated twice (operand A with IgRn input, operand B with IgRn tied 0). Its inputs are RAxE, WA3M, WA3W, RegWriteM, RegWriteW, IgRn; its output is the 2-bit select.

Test Plan:
1. Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set IgRnE=1 -> 00.
2. Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle. StallCycles advances by 1.
3. Branch: BranchTakenE=1 with no LDRstall -> FlushD=FlushE=1. PCSrcD=1 alone -> StallF=1, FlushD=1, FlushE=0.
4. Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all Stall*=1 and FlushD=FlushE=0 for 3 cycles. FSM IDLE->WAIT->IDLE, MemErr=0, StallCycles +3.
5. Timeout: MEM_TIMEOUT=4, MemReadyM held 0 for 6 cycles -> MemErr rises after the 4th wait cycle and stays 1 after MemReadyM=1. reset=1 for one edge -> MemErr=0, counters 0, FSM IDLE.
6. Saturation: CNT_W=4, StallD held for 20 cycles -> StallCycles stops at 4'hF and never wraps to 0.
